// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the Connect Four drawing path: default geometry,
// colour codes and scheduler state encoding.
package draw_scheduler_pkg;

  localparam int unsigned GRID_DEF      = 2;
  localparam int unsigned BLOCK_DEF     = 4;
  localparam int unsigned COLS_DEF      = 7;
  localparam int unsigned ROWS_DEF      = 6;
  localparam int unsigned POINTER_Y_DEF = 112;

  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_ERASE  = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ERASE_PTR,
    DRAW_PTR,
    DRAW_TOKEN
  } state_t;

  function automatic logic [2:0] player_colour(input logic player);
    return player ? COL_YELLOW : COL_RED;
  endfunction

endpackage

// File: rtl/cell_addr_gen.sv
// Combinational pixel address for one cell: cell origin from col/row (or the
// pointer line) plus a raster offset taken from the pixel counter.
module cell_addr_gen
  import draw_scheduler_pkg::*;
#(
  parameter int unsigned GRID      = GRID_DEF,
  parameter int unsigned BLOCK     = BLOCK_DEF,
  parameter int unsigned POINTER_Y = POINTER_Y_DEF,
  parameter int unsigned PIX_W     = $clog2(BLOCK * BLOCK)
) (
  input  logic [2:0]       col,
  input  logic [2:0]       row,
  input  logic             is_ptr,
  input  logic [PIX_W-1:0] pix_cnt,
  output logic [7:0]       x,
  output logic [6:0]       y
);

  logic [7:0] cx, cy, dx, dy;

  always_comb begin
    cx = 8'(32'(col) * (GRID + BLOCK) + GRID);
    cy = is_ptr ? 8'(POINTER_Y) : 8'(32'(row) * (GRID + BLOCK) + GRID);
    dx = 8'(32'(pix_cnt) % BLOCK);
    dy = 8'(32'(pix_cnt) / BLOCK);
    x  = cx + dx;
    y  = 7'(cy + dy);
  end

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates token-drop and pointer-move requests and sequences the per-cell
// pixel plots into the VGA adapter; all outputs registered.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int unsigned GRID      = GRID_DEF,
  parameter int unsigned BLOCK     = BLOCK_DEF,
  parameter int unsigned COLS      = COLS_DEF,
  parameter int unsigned ROWS      = ROWS_DEF,
  parameter int unsigned POINTER_Y = POINTER_Y_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drop_req,
  input  logic [2:0] drop_col,
  input  logic [2:0] drop_row,
  input  logic       drop_player,
  output logic       drop_ack,
  input  logic       ptr_req,
  input  logic [2:0] ptr_col,
  input  logic       ptr_player,
  output logic       ptr_ack,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned PIX_W = $clog2(BLOCK * BLOCK);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(BLOCK * BLOCK - 1);

  state_t           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [2:0]       col_q, col_d, row_q, row_d, old_col_q, old_col_d;
  logic             player_q, player_d, ptr_valid_q, ptr_valid_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [2:0]       colour_q, colour_d;
  logic             plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic             drop_ack_q, drop_ack_d, ptr_ack_q, ptr_ack_d, err_q, err_d;

  logic [2:0] addr_col;
  logic       addr_is_ptr;
  logic [7:0] addr_x;
  logic [6:0] addr_y;

  assign addr_col    = (state_q == ERASE_PTR) ? old_col_q : col_q;
  assign addr_is_ptr = (state_q != DRAW_TOKEN);

  cell_addr_gen #(
    .GRID      (GRID),
    .BLOCK     (BLOCK),
    .POINTER_Y (POINTER_Y),
    .PIX_W     (PIX_W)
  ) u_addr (
    .col     (addr_col),
    .row     (row_q),
    .is_ptr  (addr_is_ptr),
    .pix_cnt (pix_q),
    .x       (addr_x),
    .y       (addr_y)
  );

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    col_d       = col_q;
    row_d       = row_q;
    player_d    = player_q;
    old_col_d   = old_col_q;
    ptr_valid_d = ptr_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    drop_ack_d  = 1'b0;
    ptr_ack_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // plot_q high here means the final pixel is still on the bus; hold
        // off acceptance until the done cycle has passed.
        if (!plot_q) begin
          if (drop_req) begin
            drop_ack_d = 1'b1;
            if (32'(drop_col) >= COLS || 32'(drop_row) >= ROWS) begin
              err_d = 1'b1;
            end else begin
              col_d    = drop_col;
              row_d    = drop_row;
              player_d = drop_player;
              pix_d    = '0;
              state_d  = DRAW_TOKEN;
            end
          end else if (ptr_req) begin
            ptr_ack_d = 1'b1;
            if (32'(ptr_col) >= COLS) begin
              err_d = 1'b1;
            end else begin
              col_d    = ptr_col;
              player_d = ptr_player;
              pix_d    = '0;
              state_d  = ptr_valid_q ? ERASE_PTR : DRAW_PTR;
            end
          end
        end
      end
      default: begin
        plot_d   = 1'b1;
        x_d      = addr_x;
        y_d      = addr_y;
        colour_d = (state_q == ERASE_PTR) ? COL_ERASE : player_colour(player_q);
        pix_d    = pix_q + 1'b1;
        if (pix_q == PIX_LAST) begin
          pix_d = '0;
          if (state_q == ERASE_PTR) begin
            state_d = DRAW_PTR;
          end else begin
            state_d = IDLE;
            if (state_q == DRAW_PTR) begin
              old_col_d   = col_q;
              ptr_valid_d = 1'b1;
            end
          end
        end
      end
    endcase

    done_d = (state_q == IDLE) && plot_q;
    busy_d = plot_d || (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      player_q    <= 1'b0;
      old_col_q   <= '0;
      ptr_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_ack_q  <= 1'b0;
      ptr_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      col_q       <= col_d;
      row_q       <= row_d;
      player_q    <= player_d;
      old_col_q   <= old_col_d;
      ptr_valid_q <= ptr_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      drop_ack_q  <= drop_ack_d;
      ptr_ack_q   <= ptr_ack_d;
      err_q       <= err_d;
    end
  end

  assign drop_ack = drop_ack_q;
  assign ptr_ack  = ptr_ack_q;
  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign plot     = plot_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
